// File: rtl/sw_gesture.sv
// Gesture classifier: turns a debounced press level into single/double/long/repeat pulses.
// Latency: every output is registered and asserts one cycle after the edge that makes the decision.
// Backpressure: none. Events are one-cycle pulses and are never queued.
module sw_gesture #(
   parameter int p_long   = 8,
   parameter int p_gap    = 4,
   parameter int p_repeat = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_press,
   output logic o_single,
   output logic o_double,
   output logic o_long,
   output logic o_repeat,
   output logic o_busy
);

   // The shared counter must reach the largest of the three terminal counts.
   localparam int MAX_LG = (p_long > p_gap) ? p_long : p_gap;
   localparam int MAX_P  = (MAX_LG > p_repeat) ? MAX_LG : p_repeat;
   localparam int CW     = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] LONG_LAST = CW'(p_long - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(p_gap - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'((p_repeat == 0) ? 0 : p_repeat - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRESS1   = 3'd1;
   localparam logic [2:0] S_GAP      = 3'd2;
   localparam logic [2:0] S_LONG     = 3'd3;
   localparam logic [2:0] S_WAIT_REL = 3'd4;

   logic [2:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          r_prev;
   logic          ev_single, ev_double, ev_long, ev_repeat;

   // Next-state, counter and event decode; disable overrides everything.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      ev_single = 1'b0;
      ev_double = 1'b0;
      ev_long   = 1'b0;
      ev_repeat = 1'b0;
      if (!i_en) begin
         state_n = S_IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Only a genuine rise starts a gesture, so a level held across
               // reset or a disable window is ignored until released.
               if (i_press && !r_prev) begin
                  state_n = S_PRESS1;
                  cnt_n   = '0;
               end
            end
            S_PRESS1: begin
               if (i_press) begin
                  if (cnt == LONG_LAST) begin
                     ev_long = 1'b1;
                     state_n = S_LONG;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  state_n = S_GAP;
                  cnt_n   = '0;
               end
            end
            S_GAP: begin
               if (i_press) begin
                  ev_double = 1'b1;
                  state_n   = S_WAIT_REL;
                  cnt_n     = '0;
               end else if (cnt == GAP_LAST) begin
                  ev_single = 1'b1;
                  state_n   = S_IDLE;
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_LONG: begin
               if (!i_press) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end else if (p_repeat != 0) begin
                  if (cnt == REP_LAST) begin
                     ev_repeat = 1'b1;
                     cnt_n     = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  // Repeat disabled: keep the counter parked.
                  cnt_n = '0;
               end
            end
            S_WAIT_REL: begin
               // The second press of a double click produces nothing more,
               // however long it is held.
               if (!i_press) begin
                  state_n = S_IDLE;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // State, counter, press history and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         r_prev   <= 1'b1;
         o_single <= 1'b0;
         o_double <= 1'b0;
         o_long   <= 1'b0;
         o_repeat <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         r_prev   <= i_press;
         o_single <= ev_single;
         o_double <= ev_double;
         o_long   <= ev_long;
         o_repeat <= ev_repeat;
         o_busy   <= (state_n != S_IDLE);
      end
   end

endmodule
